// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg : shared constants and FSM state type for the FIR cmem ctrl  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package fir_pkg;

  localparam int DEPTH  = 64;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;
  localparam int NTAPS  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_tap_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_tap_cnt : loadable up-counter that wraps after NTAPS-1 and flags |
// |               the terminal count                                     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module fir_tap_cnt #(
  parameter int ADDR_W = 6,
  parameter int NTAPS  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              term_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/fir_coef_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_coef_seq : coefficient memory controller - streams a load into   |
// |                cmem and sweeps its read port once per sample strobe  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module fir_coef_seq #(
  parameter int DEPTH  = fir_pkg::DEPTH,
  parameter int WIDTH  = fir_pkg::WIDTH,
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int NTAPS  = fir_pkg::NTAPS
) (
  input  logic              clk2,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              samp_stb,
  output logic              cload,
  output logic [ADDR_W-1:0] caddr,
  output logic [WIDTH-1:0]  cin,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              coef_valid,
  output logic [ADDR_W-1:0] coef_idx,
  output logic              coef_first,
  output logic              coef_last,
  output logic              coef_ok,
  output logic              busy,
  output logic              samp_drop
);

  import fir_pkg::*;

  if (NTAPS < 1 || NTAPS > DEPTH || (2 ** ADDR_W) < DEPTH) begin : g_param_err
    $error("fir_coef_seq: illegal DEPTH/ADDR_W/NTAPS combination");
  end

  state_t            state_q;
  logic              cload_q;
  logic [ADDR_W-1:0] caddr_q;
  logic [WIDTH-1:0]  cin_q;
  logic              ren_q;
  logic              cvalid_q;
  logic [ADDR_W-1:0] cidx_q;
  logic              cfirst_q;
  logic              clast_q;
  logic              ok_q;
  logic              busy_q;
  logic              drop_q;

  logic [ADDR_W-1:0] wcnt;
  logic              wterm;
  logic [ADDR_W-1:0] rcnt;
  logic              rterm;
  logic              w_ld;
  logic              w_en;
  logic              r_ld;
  logic              r_en;

  // A strobe on the last tap reloads the read counter so the sweep restarts without a bubble.
  assign w_ld = (state_q == IDLE) & cfg_start;
  assign w_en = (state_q == LOAD) & cfg_valid;
  assign r_ld = ((state_q == IDLE) & ~cfg_start & samp_stb & ok_q)
              | ((state_q == SWEEP) & rterm & samp_stb);
  assign r_en = (state_q == SWEEP);

  fir_tap_cnt #(.ADDR_W(ADDR_W), .NTAPS(NTAPS)) u_wcnt (
    .clk      (clk2),
    .rst_n    (rstn),
    .ld_i     (w_ld),
    .ld_val_i ('0),
    .en_i     (w_en),
    .cnt_o    (wcnt),
    .term_o   (wterm)
  );

  fir_tap_cnt #(.ADDR_W(ADDR_W), .NTAPS(NTAPS)) u_rcnt (
    .clk      (clk2),
    .rst_n    (rstn),
    .ld_i     (r_ld),
    .ld_val_i ('0),
    .en_i     (r_en),
    .cnt_o    (rcnt),
    .term_o   (rterm)
  );

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cload_q  <= 1'b0;
      caddr_q  <= '0;
      cin_q    <= '0;
      ren_q    <= 1'b0;
      cvalid_q <= 1'b0;
      cidx_q   <= '0;
      cfirst_q <= 1'b0;
      clast_q  <= 1'b0;
      ok_q     <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      cload_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= LOAD;
            ok_q    <= 1'b0;
            busy_q  <= 1'b1;
            if (samp_stb) drop_q <= 1'b1;
          end else if (samp_stb) begin
            if (ok_q) begin
              state_q <= SWEEP;
              ren_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (samp_stb) drop_q <= 1'b1;
          if (cfg_valid) begin
            cload_q <= 1'b1;
            caddr_q <= wcnt;
            cin_q   <= cfg_data;
            if (wterm) begin
              state_q <= IDLE;
              ok_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        SWEEP: begin
          if (rterm) begin
            if (!samp_stb) begin
              state_q <= IDLE;
              ren_q   <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else if (samp_stb) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
      // cmem read latency is one cycle; tap tags follow the read request by one edge.
      cvalid_q <= ren_q;
      cidx_q   <= rcnt;
      cfirst_q <= ren_q & (rcnt == '0);
      clast_q  <= ren_q & rterm;
    end
  end

  assign cfg_ready  = (state_q == LOAD);
  assign cload      = cload_q;
  assign caddr      = caddr_q;
  assign cin        = cin_q;
  assign ren        = ren_q;
  assign raddr      = rcnt;
  assign coef_valid = cvalid_q;
  assign coef_idx   = cidx_q;
  assign coef_first = cfirst_q;
  assign coef_last  = clast_q;
  assign coef_ok    = ok_q;
  assign busy       = busy_q;
  assign samp_drop  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_coef_seq : directed bench for fir_coef_seq with a cmem model  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_fir_coef_seq;

  localparam int DEPTH  = 64;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 6;
  localparam int NTAPS  = 64;

  logic              clk2      = 1'b0;
  logic              rstn      = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              samp_stb  = 1'b0;
  logic [WIDTH-1:0]  cfg_data  = '0;
  logic              cfg_ready, cload, ren, coef_valid, coef_first, coef_last;
  logic              coef_ok, busy, samp_drop;
  logic [ADDR_W-1:0] caddr, raddr, coef_idx;
  logic [WIDTH-1:0]  cin;

  logic [WIDTH-1:0]  cmem [DEPTH];
  logic [WIDTH-1:0]  cout;
  logic [WIDTH-1:0]  shadow [NTAPS];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [WIDTH-1:0]  wr_data [$];
  logic              overlap = 1'b0;
  logic [42:0]       all_out;

  int checks = 0;
  int errors = 0;

  int ld_ready, ld_ren;
  bit ld_to;
  int sw_ren, sw_maxrun, sw_valid, sw_bad, sw_first, sw_last, sw_ren1, sw_val1;
  bit sw_to;

  always #5 clk2 = ~clk2;

  fir_coef_seq #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NTAPS(NTAPS)) dut (
    .clk2       (clk2),
    .rstn       (rstn),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .samp_stb   (samp_stb),
    .cload      (cload),
    .caddr      (caddr),
    .cin        (cin),
    .ren        (ren),
    .raddr      (raddr),
    .coef_valid (coef_valid),
    .coef_idx   (coef_idx),
    .coef_first (coef_first),
    .coef_last  (coef_last),
    .coef_ok    (coef_ok),
    .busy       (busy),
    .samp_drop  (samp_drop)
  );

  assign all_out = {cfg_ready, cload, caddr, cin, ren, raddr, coef_valid, coef_idx,
                    coef_first, coef_last, coef_ok, busy, samp_drop};

  always @(posedge clk2) begin
    if (cload) cmem[caddr] <= cin;
    if (ren)   cout <= cmem[raddr];
  end

  always @(negedge clk2) begin
    if (cload) begin
      wr_addr.push_back(caddr);
      wr_data.push_back(cin);
    end
    if (cload && ren) overlap = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic fill_shadow();
    for (int i = 0; i < NTAPS; i++) shadow[i] = 16'($urandom);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk2);
    rstn = 1'b1;
    @(negedge clk2);
  endtask

  task automatic do_load(input bit with_samp, input bit gap, input int nbeats);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    ld_ready = 0;
    ld_ren = 0;
    @(negedge clk2);
    cfg_start = 1'b1;
    samp_stb  = with_samp;
    @(negedge clk2);
    cfg_start = 1'b0;
    samp_stb  = 1'b0;
    while (idx < nbeats && cyc < 400) begin
      cyc++;
      if (ren) ld_ren++;
      if (gap && (cyc % 3 == 0)) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = shadow[idx];
      end
      if (cfg_ready) ld_ready++;
      if (cfg_valid && cfg_ready) idx++;
      @(negedge clk2);
    end
    cfg_valid = 1'b0;
    ld_to = (idx < nbeats);
  endtask

  task automatic do_sweep(input bit b2b);
    int cyc;
    int run;
    int pulses;
    int e;
    cyc = 0; run = 0; pulses = 0;
    sw_ren = 0; sw_maxrun = 0; sw_valid = 0; sw_bad = 0;
    sw_first = 0; sw_last = 0; sw_ren1 = -1; sw_val1 = -1;
    @(negedge clk2);
    samp_stb = 1'b1;
    @(negedge clk2);
    samp_stb = 1'b0;
    while (cyc < 400) begin
      cyc++;
      if (ren) begin
        run++;
        sw_ren++;
        if (sw_ren1 < 0) sw_ren1 = cyc;
        if (cyc == sw_ren1 && raddr !== '0) sw_bad++;
      end else begin
        run = 0;
      end
      if (run > sw_maxrun) sw_maxrun = run;
      if (coef_valid) begin
        if (sw_val1 < 0) sw_val1 = cyc;
        e = sw_valid % NTAPS;
        if (coef_idx !== ADDR_W'(e) || cout !== shadow[e]) sw_bad++;
        if (coef_first !== (e == 0)) sw_bad++;
        if (coef_last !== (e == NTAPS - 1)) sw_bad++;
        if (coef_first) sw_first++;
        if (coef_last) sw_last++;
        sw_valid++;
      end else if (coef_first || coef_last) begin
        sw_bad++;
      end
      if (!busy && !ren && !coef_valid && cyc > 2) break;
      if (b2b && pulses == 0 && ren && raddr == 6'd63) begin
        samp_stb = 1'b1;
        pulses = 1;
      end else if (b2b && pulses == 1 && ren && raddr == 6'd10) begin
        samp_stb = 1'b1;
        pulses = 2;
      end else begin
        samp_stb = 1'b0;
      end
      @(negedge clk2);
    end
    samp_stb = 1'b0;
    sw_to = (cyc >= 400);
  endtask

  task automatic test_reset();
    @(negedge clk2);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rstn = 1'b1;
    @(negedge clk2);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b cfg_ready=%b want 0/0", busy, cfg_ready);
    end
  endtask

  task automatic test_no_coef();
    int seen;
    seen = 0;
    @(negedge clk2);
    samp_stb = 1'b1;
    @(negedge clk2);
    samp_stb = 1'b0;
    repeat (5) begin
      if (ren || busy) seen++;
      @(negedge clk2);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_coef_ren: got %0d active cycles want 0", seen);
    end
    checks++;
    if (samp_drop !== 1'b1) begin
      errors++;
      $display("FAIL no_coef_drop: got samp_drop=%b want 1", samp_drop);
    end
  endtask

  task automatic test_start_priority();
    apply_reset();
    checks++;
    if (samp_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_cleared: got samp_drop=%b want 0", samp_drop);
    end
    fill_shadow();
    do_load(1'b1, 1'b0, NTAPS);
    checks++;
    if (ld_to || ld_ready !== NTAPS || ld_ren !== 0) begin
      errors++;
      $display("FAIL start_priority_load: got to=%b ready=%0d ren=%0d want 0/64/0", ld_to, ld_ready, ld_ren);
    end
    checks++;
    if (samp_drop !== 1'b1) begin
      errors++;
      $display("FAIL start_priority_drop: got samp_drop=%b want 1", samp_drop);
    end
  endtask

  task automatic test_load();
    int bad;
    fill_shadow();
    wr_addr.delete();
    wr_data.delete();
    do_load(1'b0, 1'b0, NTAPS);
    checks++;
    if (ld_to || ld_ready !== NTAPS) begin
      errors++;
      $display("FAIL load_ready: got to=%b ready=%0d want 0/64", ld_to, ld_ready);
    end
    checks++;
    if (coef_ok !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got ok=%b busy=%b ready=%b want 1/0/0", coef_ok, busy, cfg_ready);
    end
    @(negedge clk2);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (i >= NTAPS || wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== shadow[i]) bad++;
    checks++;
    if (wr_addr.size() !== NTAPS || bad !== 0) begin
      errors++;
      $display("FAIL load_writes: got %0d writes %0d bad want 64/0", wr_addr.size(), bad);
    end
    do_sweep(1'b0);
    checks++;
    if (sw_to || sw_valid !== NTAPS || sw_bad !== 0) begin
      errors++;
      $display("FAIL load_readback: got to=%b valid=%0d bad=%0d want 0/64/0", sw_to, sw_valid, sw_bad);
    end
  endtask

  task automatic test_gap_load();
    int bad;
    fill_shadow();
    wr_addr.delete();
    wr_data.delete();
    do_load(1'b0, 1'b1, NTAPS);
    @(negedge clk2);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (i >= NTAPS || wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== shadow[i]) bad++;
    checks++;
    if (ld_to || wr_addr.size() !== NTAPS || bad !== 0) begin
      errors++;
      $display("FAIL gap_load_writes: got to=%b writes=%0d bad=%0d want 0/64/0", ld_to, wr_addr.size(), bad);
    end
    checks++;
    if (coef_ok !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_load_done: got ok=%b busy=%b want 1/0", coef_ok, busy);
    end
  endtask

  task automatic test_sweep();
    do_sweep(1'b0);
    checks++;
    if (sw_to || sw_ren !== NTAPS || sw_maxrun !== NTAPS) begin
      errors++;
      $display("FAIL sweep_ren: got to=%b ren=%0d run=%0d want 0/64/64", sw_to, sw_ren, sw_maxrun);
    end
    checks++;
    if (sw_ren1 !== 1 || sw_val1 !== 2) begin
      errors++;
      $display("FAIL sweep_latency: got ren@%0d valid@%0d want 1/2", sw_ren1, sw_val1);
    end
    checks++;
    if (sw_valid !== NTAPS || sw_bad !== 0 || sw_first !== 1 || sw_last !== 1) begin
      errors++;
      $display("FAIL sweep_data: got valid=%0d bad=%0d first=%0d last=%0d want 64/0/1/1",
               sw_valid, sw_bad, sw_first, sw_last);
    end
    checks++;
    if (samp_drop !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_drop: got samp_drop=%b want 0", samp_drop);
    end
  endtask

  task automatic test_back_to_back();
    do_sweep(1'b1);
    checks++;
    if (sw_to || sw_ren !== 2 * NTAPS || sw_maxrun !== 2 * NTAPS) begin
      errors++;
      $display("FAIL b2b_ren: got to=%b ren=%0d run=%0d want 0/128/128", sw_to, sw_ren, sw_maxrun);
    end
    checks++;
    if (sw_valid !== 2 * NTAPS || sw_bad !== 0 || sw_first !== 2 || sw_last !== 2) begin
      errors++;
      $display("FAIL b2b_data: got valid=%0d bad=%0d first=%0d last=%0d want 128/0/2/2",
               sw_valid, sw_bad, sw_first, sw_last);
    end
    checks++;
    if (samp_drop !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop: got samp_drop=%b want 1", samp_drop);
    end
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL cload_ren_overlap: got %b want 0", overlap);
    end
  endtask

  task automatic test_midload_reset();
    int seen;
    fill_shadow();
    do_load(1'b0, 1'b0, 20);
    checks++;
    if (ld_to || busy !== 1'b1 || cfg_ready !== 1'b1 || coef_ok !== 1'b0) begin
      errors++;
      $display("FAIL midload_state: got to=%b busy=%b ready=%b ok=%b want 0/1/1/0", ld_to, busy, cfg_ready, coef_ok);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL midload_async_reset: got %h want 0", all_out);
    end
    @(negedge clk2);
    rstn = 1'b1;
    @(negedge clk2);
    samp_stb = 1'b1;
    @(negedge clk2);
    samp_stb = 1'b0;
    seen = 0;
    repeat (4) begin
      if (ren) seen++;
      @(negedge clk2);
    end
    checks++;
    if (coef_ok !== 1'b0 || seen !== 0) begin
      errors++;
      $display("FAIL midload_not_ok: got ok=%b ren_cycles=%0d want 0/0", coef_ok, seen);
    end
    test_load();
  endtask

  initial begin
    test_reset();
    test_no_coef();
    test_start_priority();
    apply_reset();
    test_load();
    test_gap_load();
    test_sweep();
    test_back_to_back();
    test_midload_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
